// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Which redirect source wins this cycle, highest priority first.
  typedef enum logic [1:0] {
    REDIR_NONE     = 2'd0,
    REDIR_TRAP     = 2'd1,
    REDIR_BRANCH   = 2'd2,
    REDIR_MISALIGN = 2'd3
  } redir_sel_e;

  function automatic redir_sel_e redir_select(input logic trap,
                                              input logic taken,
                                              input logic [1:0] tgt_lsb);
    if (trap)                  return REDIR_TRAP;
    else if (taken && tgt_lsb == 2'b00) return REDIR_BRANCH;
    else if (taken)            return REDIR_MISALIGN;
    else                       return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: hazard/execute/imem inputs and PC-register outputs.
interface fetch_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [31:0]            pcf_q;
  logic                   imem_ready;
  logic                   hazard_stall;
  logic                   branch_taken_e;
  logic [31:0]            branch_target_e;
  logic                   trap_req;
  logic [31:0]            pcf_next;
  logic                   stall_f;
  logic                   flush_d;
  logic                   misalign_err;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    input  pcf_q, imem_ready, hazard_stall, branch_taken_e, branch_target_e, trap_req,
    output pcf_next, stall_f, flush_d, misalign_err, stall_cnt
  );

  modport slave (
    output pcf_q, imem_ready, hazard_stall, branch_taken_e, branch_target_e, trap_req,
    input  pcf_next, stall_f, flush_d, misalign_err, stall_cnt
  );
endinterface

// File: rtl/fetch_ctrl_redirect_resolve.sv
// Trap/branch/misaligned-branch priority resolution for PC redirects.
module redirect_resolve
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        trap_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        valid,
  output logic [31:0] target,
  output logic        misalign
);

  redir_sel_e sel;

  // Pick the winning redirect source and its target.
  always_comb begin
    sel      = redir_select(trap_req, branch_taken, branch_target[1:0]);
    valid    = 1'b0;
    target   = TRAP_VECTOR;
    misalign = 1'b0;
    case (sel)
      REDIR_TRAP:     valid = 1'b1;
      REDIR_BRANCH:   begin valid = 1'b1; target = branch_target; end
      REDIR_MISALIGN: begin valid = 1'b1; misalign = 1'b1; end
      default:        ;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC select, fetch stall, decode flush, stall counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic        clk,
  input logic        reset_n,
  fetch_ctrl_if.master bus
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  fetch_state_e           state;
  logic [7:0]             boot_cnt;
  logic                   pend_valid;
  logic [31:0]            pend_target;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic        rr_valid;
  logic [31:0] rr_target;
  logic        rr_misalign;

  logic [31:0] pcf_next;
  logic        stall_f;
  logic        flush_d;
  logic        misalign_err;

  redirect_resolve #(.TRAP_VECTOR(TRAP_VECTOR)) u_resolve (
    .trap_req      (bus.trap_req),
    .branch_taken  (bus.branch_taken_e),
    .branch_target (bus.branch_target_e),
    .valid         (rr_valid),
    .target        (rr_target),
    .misalign      (rr_misalign)
  );

  // Same-cycle outputs from registered state and current inputs; BOOT and
  // illegal encodings hold fetch at RESET_PC.
  always_comb begin
    pcf_next     = RESET_PC;
    stall_f      = 1'b1;
    flush_d      = 1'b1;
    misalign_err = 1'b0;
    case (state)
      RUN: begin
        misalign_err = rr_misalign;
        if (rr_valid) begin
          stall_f  = 1'b0;
          pcf_next = rr_target;
        end else if (bus.hazard_stall) begin
          pcf_next = bus.pcf_q;
          flush_d  = 1'b0;
        end else if (!bus.imem_ready) begin
          pcf_next = bus.pcf_q;
        end else begin
          stall_f  = 1'b0;
          flush_d  = 1'b0;
          pcf_next = bus.pcf_q + PC_STEP;
        end
      end
      WAIT_MEM: begin
        misalign_err = rr_misalign;
        pcf_next     = bus.pcf_q;
        if (bus.imem_ready) begin
          stall_f = 1'b0;
          // A redirect arriving this cycle is newer than the latched one.
          if (rr_valid)        pcf_next = rr_target;
          else if (pend_valid) pcf_next = pend_target;
          else begin
            pcf_next = bus.pcf_q + PC_STEP;
            flush_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // State sequencing, boot hold counter and pending-redirect latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 8'd1;
          if (boot_cnt == BOOT_LAST) state <= RUN;
        end
        RUN: begin
          pend_valid <= 1'b0;
          if (!rr_valid && !bus.hazard_stall && !bus.imem_ready) state <= WAIT_MEM;
        end
        WAIT_MEM: begin
          if (bus.imem_ready) begin
            state      <= RUN;
            pend_valid <= 1'b0;
          end else if (rr_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= rr_target;
          end
        end
        default: begin
          state      <= BOOT;
          boot_cnt   <= '0;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles outside boot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall_f && (state == RUN || state == WAIT_MEM) && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.pcf_next     = pcf_next;
  assign bus.stall_f      = stall_f;
  assign bus.flush_d      = flush_d;
  assign bus.misalign_err = misalign_err;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer for the PC register: computes the next PC value and the fetch-stage stall each cycle.
- Arbitrates between boot hold, instruction-memory wait, load-use stall, execute-stage branch redirect and trap redirect.
- Produces the decode-stage flush.
- Sits between the hazard unit, the execute stage, the instruction memory port and the PC register.

Parameters:
- RESET_PC, 32'h0000_0000, PC the PC register holds after reset. Must equal the PC register's reset value.
- TRAP_VECTOR, 32'h0000_0100, redirect target for trap_req and for misaligned branch targets.
- BOOT_CYCLES, 4, number of cycles fetch is held stalled after reset release (1..255).
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pcf_q  in  32  current PC from the PC register
- imem_ready  in  1  instruction at pcf_q is available this cycle
- hazard_stall  in  1  load-use stall request from the hazard unit
- branch_taken_e  in  1  execute-stage taken branch/jump
- branch_target_e  in  32  branch/jump target
- trap_req  in  1  synchronous trap/exception request
- pcf_next  out  32  next PC to the PC register input
- stall_f  out  1  fetch stall to the PC register
- flush_d  out  1  kill the instruction in the IF/ID register
- misalign_err  out  1  one-cycle pulse: branch target with [1:0] != 0 was replaced by TRAP_VECTOR
- stall_cnt  out  STALL_CNT_W  saturating count of stall_f=1 cycles in RUN/WAIT_MEM

Behaviour:
- Reset (async, reset_n=0):
  - state=BOOT, boot_cnt=0, pend_valid=0, pend_target=0, stall_cnt=0.
  - Outputs during reset: stall_f=1, flush_d=1, pcf_next=RESET_PC, misalign_err=0.
- Output timing: pcf_next, stall_f, flush_d and misalign_err are combinational from registered state and current inputs. They are consumed by the PC register in the same cycle, so PC redirect latency is 1 edge.
- Redirect resolution, in this priority order:
  - trap_req → TRAP_VECTOR.
  - else branch_taken_e with branch_target_e[1:0]==0 → branch_target_e.
  - else branch_taken_e with misaligned target → TRAP_VECTOR, and misalign_err=1.
- States:
  - BOOT:
    - Outputs: stall_f=1, flush_d=1, pcf_next=RESET_PC.
    - boot_cnt increments each cycle; at boot_cnt==BOOT_CYCLES-1 go to RUN.
    - Redirect inputs are ignored.
  - RUN:
    - Redirect present: stall_f=0, pcf_next=target, flush_d=1, regardless of hazard_stall and imem_ready. Stay in RUN.
    - Else hazard_stall=1: stall_f=1, pcf_next=pcf_q, flush_d=0.
    - Else imem_ready=0: stall_f=1, pcf_next=pcf_q, flush_d=1 (bubble), go to WAIT_MEM.
    - Else: stall_f=0, pcf_next=pcf_q+4 (mod 2^32, wraps FFFF_FFFC→0000_0000), flush_d=0.
  - WAIT_MEM:
    - Outputs: stall_f=1, flush_d=1, pcf_next=pcf_q.
    - A redirect arriving here is latched: pend_valid=1, pend_target=resolved target. A later redirect overwrites an earlier one; trap beats branch in the same cycle.
    - misalign_err still pulses in the cycle the misaligned branch arrives.
    - When imem_ready=1 and a redirect is pending (latched earlier, or arriving this cycle): stall_f=0, pcf_next=pending/arriving target, flush_d=1, pend_valid cleared, go to RUN.
    - When imem_ready=1 with nothing pending: stall_f=0, pcf_next=pcf_q+4, flush_d=0, go to RUN. hazard_stall is sampled again in RUN.
- stall_cnt: +1 on every cycle with stall_f=1 in RUN or WAIT_MEM. Saturates at all-ones. Never counts in BOOT.
- Reset asserted mid-operation: immediate return to reset values; any pending redirect is discarded.
- Illegal state encoding: treated as BOOT on the next edge.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {BOOT, RUN, WAIT_MEM};
  - the constant PC_STEP=4;
  - the redirect-priority encoding.
- One natural sub-module, redirect_resolve: combinational trap/branch/misalign priority, outputs valid, target and misalign.
- Counter and FSM stay in fetch_ctrl.

Test Plan:
- Boot hold: release reset_n with BOOT_CYCLES=4, imem_ready=1 → stall_f=1, flush_d=1 for 4 cycles. On the 5th cycle pcf_next=0x4, stall_f=0.
- Sequential fetch with wrap: pcf_q=0xFFFF_FFFC, imem_ready=1 → pcf_next=0x0000_0000, stall_f=0, flush_d=0.
- Load-use vs branch: hazard_stall=1 alone → stall_f=1, pcf_next=pcf_q, stall_cnt+1. Same cycle with branch_taken_e=1, target 0x200 → stall_f=0, pcf_next=0x200, flush_d=1.
- Redirect during memory wait, in order:
  - imem_ready=0 at pcf_q=0x40 → state enters WAIT_MEM.
  - Branch to 0x80 arrives while waiting, then trap_req arrives → pend_target=0x100.
  - imem_ready=1 → pcf_next=0x100, flush_d=1, state returns to RUN.
- Misaligned target: branch_taken_e=1, target 0x202 in RUN → pcf_next=0x100, misalign_err=1 for exactly one cycle.
- Async reset mid-WAIT_MEM with pend_valid=1: drop reset_n between edges → outputs reset values immediately, pend_valid=0, stall_cnt=0, and after release fetch restarts from BOOT.
